// File: rtl/dtb_capture_ctrl.sv
// Capture run sequencer for the Tracer datapath: arm, wait for trigger, post-trigger
// delay, flush to the next memory-word boundary, done. Streaming mode only gates EN_O.
module dtb_capture_ctrl #(
  parameter int DELAY_W = 16
) (
  input  logic               FPGA_CLK_I,
  input  logic               RST_I,
  input  logic               ARM_I,
  input  logic               MODE_I,
  input  logic [DELAY_W-1:0] TRG_DELAY_I,
  input  logic               TRIGGER_I,
  input  logic               STORE_I,
  output logic               EN_O,
  output logic               TRG_EVENT_O,
  output logic               BUSY_O,
  output logic               DONE_O,
  output logic [DELAY_W-1:0] WORD_CNT_O,
  output logic [2:0]         STATE_O
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_DELAY  = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4,
    S_STREAM = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               arm_q;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] wcnt_q, wcnt_d;
  logic               en_q, trg_q, busy_q, done_q;
  logic               arm_rise;

  assign arm_rise = ARM_I & ~arm_q;

  // ARM_I low in any active state aborts, ahead of trigger/store handling.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;

    if (state_q == S_IDLE && arm_rise) begin
      wcnt_d = '0;
    end else if (STORE_I && en_q && wcnt_q != {DELAY_W{1'b1}}) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (arm_rise) begin
          dly_d   = TRG_DELAY_I;
          state_d = MODE_I ? S_STREAM : S_ARMED;
        end
      end
      S_ARMED: begin
        if (!ARM_I) begin
          state_d = S_IDLE;
        end else if (TRIGGER_I) begin
          if (dly_q == '0) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d   = dly_q;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        cnt_d = cnt_q - 1'b1;
        if (!ARM_I) begin
          state_d = S_IDLE;
        end else if (cnt_q == {{(DELAY_W-1){1'b0}}, 1'b1}) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!ARM_I) begin
          state_d = S_IDLE;
        end else if (STORE_I) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_STREAM: begin
        if (!ARM_I) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      dly_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      en_q    <= 1'b0;
      trg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= ARM_I;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      en_q    <= (state_d == S_ARMED) || (state_d == S_DELAY) ||
                 (state_d == S_FLUSH) || (state_d == S_STREAM);
      busy_q  <= (state_d == S_ARMED) || (state_d == S_DELAY) ||
                 (state_d == S_FLUSH) || (state_d == S_STREAM);
      trg_q   <= (state_d == S_FLUSH) || (state_d == S_DONE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign EN_O        = en_q;
  assign TRG_EVENT_O = trg_q;
  assign BUSY_O      = busy_q;
  assign DONE_O      = done_q;
  assign WORD_CNT_O  = wcnt_q;
  assign STATE_O     = state_q;

endmodule

// File: tb/tb_dtb_capture_ctrl.sv
// Directed bench for dtb_capture_ctrl: trace-buffer runs, zero delay, stale trigger,
// streaming, abort, word-count saturation and mid-run reset.
module tb_dtb_capture_ctrl;
  localparam int DELAY_W = 16;

  // Expected {EN_O, TRG_EVENT_O, BUSY_O, DONE_O}
  localparam logic [3:0] O_IDLE  = 4'b0000;
  localparam logic [3:0] O_BUSY  = 4'b1010;
  localparam logic [3:0] O_FLUSH = 4'b1110;
  localparam logic [3:0] O_DONE  = 4'b0101;

  logic               clk = 1'b0;
  logic               rst;
  logic               arm;
  logic               mode;
  logic [DELAY_W-1:0] dly;
  logic               trig;
  logic               store;
  logic               EN_O, TRG_EVENT_O, BUSY_O, DONE_O;
  logic [DELAY_W-1:0] WORD_CNT_O;
  logic [2:0]         STATE_O;

  int n_vec = 0;
  int n_err = 0;

  dtb_capture_ctrl #(.DELAY_W(DELAY_W)) dut (
    .FPGA_CLK_I  (clk),
    .RST_I       (rst),
    .ARM_I       (arm),
    .MODE_I      (mode),
    .TRG_DELAY_I (dly),
    .TRIGGER_I   (trig),
    .STORE_I     (store),
    .EN_O        (EN_O),
    .TRG_EVENT_O (TRG_EVENT_O),
    .BUSY_O      (BUSY_O),
    .DONE_O      (DONE_O),
    .WORD_CNT_O  (WORD_CNT_O),
    .STATE_O     (STATE_O)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {EN_O, TRG_EVENT_O, BUSY_O, DONE_O};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: en/trg/busy/done got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [DELAY_W-1:0] exp);
    n_vec++;
    assert (WORD_CNT_O === exp) else begin
      n_err++;
      $error("FAIL %s: word_cnt got %0d expected %0d", tag, WORD_CNT_O, exp);
    end
  endtask

  initial begin
    logic done_seen;
    rst = 1'b1; arm = 1'b0; mode = 1'b0; dly = '0; trig = 1'b0; store = 1'b0;

    // Reset and idle
    ticks(2);
    chk_out("reset_outs", O_IDLE);
    chk_cnt("reset_cnt", 16'd0);
    rst = 1'b0;
    ticks(10);
    chk_out("idle_outs", O_IDLE);
    chk_cnt("idle_cnt", 16'd0);

    // Trace-buffer run, delay 5; latched config must survive mid-run changes
    mode = 1'b0; dly = 16'd5; arm = 1'b1;
    tick();
    chk_out("t2_armed", O_BUSY);
    chk_cnt("t2_arm_clr", 16'd0);
    mode = 1'b1; dly = 16'd0;
    store = 1'b1; tick(); store = 1'b0;
    chk_cnt("t2_store1", 16'd1);
    ticks(3);
    chk_out("t2_still_armed", O_BUSY);
    trig = 1'b1; tick(); trig = 1'b0;
    chk_out("t2_delay_entry", O_BUSY);
    tick(); chk_out("t2_delay1", O_BUSY);
    store = 1'b1; tick(); store = 1'b0;
    chk_out("t2_delay2", O_BUSY);
    chk_cnt("t2_store2", 16'd2);
    tick(); chk_out("t2_delay3", O_BUSY);
    tick(); chk_out("t2_delay4", O_BUSY);
    tick(); chk_out("t2_flush", O_FLUSH);
    ticks(3); chk_out("t2_flush_hold", O_FLUSH);
    store = 1'b1; tick(); store = 1'b0;
    chk_out("t2_done", O_DONE);
    chk_cnt("t2_done_cnt", 16'd3);
    ticks(3);
    chk_out("t2_done_hold", O_DONE);
    store = 1'b1; tick(); store = 1'b0;
    chk_cnt("t2_done_nocount", 16'd3);
    arm = 1'b0; tick();
    chk_out("t2_release", O_IDLE);
    chk_cnt("t2_idle_cnt", 16'd3);

    // Zero delay, trigger coincident with a store
    mode = 1'b0; dly = 16'd0; arm = 1'b1;
    tick();
    chk_out("t3_armed", O_BUSY);
    chk_cnt("t3_arm_clr", 16'd0);
    trig = 1'b1; store = 1'b1; tick(); trig = 1'b0; store = 1'b0;
    chk_out("t3_flush", O_FLUSH);
    chk_cnt("t3_cnt1", 16'd1);
    tick(); chk_out("t3_flush_hold", O_FLUSH);
    store = 1'b1; tick(); store = 1'b0;
    chk_out("t3_done", O_DONE);
    chk_cnt("t3_cnt2", 16'd2);
    arm = 1'b0; tick();
    chk_out("t3_idle", O_IDLE);

    // Stale trigger on arm, then abort in FLUSH
    trig = 1'b1; arm = 1'b1; dly = 16'd0;
    tick(); chk_out("stale_armed", O_BUSY);
    tick(); chk_out("stale_flush", O_FLUSH);
    trig = 1'b0; arm = 1'b0; store = 1'b1; tick(); store = 1'b0;
    chk_out("stale_abort", O_IDLE);

    // Streaming mode
    mode = 1'b1; dly = 16'd3; arm = 1'b1;
    tick();
    chk_out("t4_stream", O_BUSY);
    chk_cnt("t4_clr", 16'd0);
    for (int i = 0; i < 3; i++) begin
      trig = ~trig; store = 1'b1; tick();
      store = 1'b0; trig = ~trig; tick();
    end
    chk_out("t4_stream_hold", O_BUSY);
    chk_cnt("t4_cnt3", 16'd3);
    arm = 1'b0; tick();
    chk_out("t4_idle", O_IDLE);
    chk_cnt("t4_idle_cnt", 16'd3);

    // Abort in DELAY with trigger and store high
    mode = 1'b0; dly = 16'd10; arm = 1'b1;
    tick(); chk_out("t5_armed", O_BUSY);
    trig = 1'b1; tick();
    chk_out("t5_delay", O_BUSY);
    ticks(2);
    arm = 1'b0; store = 1'b1; tick(); store = 1'b0;
    chk_out("t5_abort", O_IDLE);
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      done_seen |= DONE_O;
    end
    trig = 1'b0;
    n_vec++;
    assert (done_seen === 1'b0) else begin
      n_err++;
      $error("FAIL t5_no_done: done_seen got %b expected 0", done_seen);
    end

    // Saturation in streaming, then reset mid-run
    mode = 1'b1; arm = 1'b1;
    tick(); chk_out("t6_stream", O_BUSY);
    store = 1'b1;
    ticks((1 << DELAY_W) + 2);
    chk_out("t6_stream_hold", O_BUSY);
    chk_cnt("t6_sat", 16'hFFFF);
    rst = 1'b1; tick();
    chk_out("t6_reset", O_IDLE);
    chk_cnt("t6_reset_cnt", 16'd0);
    rst = 1'b0; store = 1'b0; arm = 1'b0;
    ticks(2);
    chk_out("t6_after_reset", O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
